move_checker: RTL and testbench

MOVE_CHECKER -- requirements
Module: move_checker

---
 rtl/move_checker.sv | 160 ++++++++++++++++
 tb/tb_move_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_checker.sv
// Sudoku-style move checker for a 4x4 board: scans the target's row, column and box,
// then either rejects the move or writes it and recounts the board to update solved.
module move_checker (
  input  logic       clka,
  input  logic       restart_n,
  input  logic       check_flag,
  input  logic       new_game,
  input  logic [1:0] row,
  input  logic [1:0] col,
  input  logic [2:0] val,
  output logic [3:0] rd_addr,
  input  logic [2:0] rd_data,
  input  logic       rd_given,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [2:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       move_ok,
  output logic       solved
);

  typedef enum logic [2:0] {IDLE, LOCK, SCAN, WRITE, COUNT, FIN} state_t;

  state_t     state, state_next;
  logic [4:0] idx, idx_next;
  logic [1:0] tgt_row, tgt_col;
  logic [2:0] tgt_val;
  logic [3:0] tgt_addr;
  logic [3:0] prev_addr;
  logic [3:0] scan_addr;
  logic [4:0] count, count_next;
  logic       reject, reject_next;
  logic       move_ok_next, solved_next;
  logic       accept;
  logic       given_hit, conflict_hit;

  assign tgt_addr = {tgt_row, tgt_col};

  // Scan order: row cells, column cells, then the 2x2 box row-major.
  always_comb begin
    scan_addr = 4'd0;
    case (idx[3:2])
      2'd0:    scan_addr = {tgt_row, idx[1:0]};
      2'd1:    scan_addr = {idx[1:0], tgt_col};
      2'd2:    scan_addr = {tgt_row[1], idx[1], tgt_col[1], idx[0]};
      default: scan_addr = 4'd0;
    endcase
  end

  // Data seen in SCAN slot 0 belongs to the LOCK read of the target itself.
  assign given_hit    = (idx == 5'd0) && rd_given;
  assign conflict_hit = (idx != 5'd0) && (tgt_val != 3'd0) &&
                        (prev_addr != tgt_addr) && (rd_data == tgt_val);

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    reject_next  = reject;
    count_next   = count;
    move_ok_next = move_ok;
    solved_next  = solved;
    accept       = 1'b0;
    rd_addr      = 4'd0;
    wr_en        = 1'b0;
    wr_addr      = 4'd0;
    wr_data      = 3'd0;
    busy         = (state != IDLE);
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (check_flag) begin
          accept       = 1'b1;
          state_next   = LOCK;
          idx_next     = 5'd0;
          reject_next  = 1'b0;
          count_next   = 5'd0;
          move_ok_next = 1'b0;
        end
      end
      LOCK: begin
        rd_addr    = tgt_addr;
        state_next = SCAN;
        idx_next   = 5'd0;
      end
      SCAN: begin
        if (idx < 5'd12) rd_addr = scan_addr;
        reject_next = reject | given_hit | conflict_hit | (tgt_val > 3'd4);
        if (idx == 5'd12) begin
          idx_next   = 5'd0;
          state_next = reject_next ? FIN : WRITE;
        end else begin
          idx_next = idx + 5'd1;
        end
      end
      WRITE: begin
        wr_en      = 1'b1;
        wr_addr    = tgt_addr;
        wr_data    = tgt_val;
        state_next = COUNT;
        idx_next   = 5'd0;
        count_next = 5'd0;
      end
      COUNT: begin
        if (idx < 5'd16) rd_addr = idx[3:0];
        if ((idx != 5'd0) && (rd_data != 3'd0)) count_next = count + 5'd1;
        if (idx == 5'd16) begin
          state_next   = FIN;
          move_ok_next = 1'b1;
          solved_next  = (count_next == 5'd16);
        end else begin
          idx_next = idx + 5'd1;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (new_game) begin
      state_next   = IDLE;
      accept       = 1'b0;
      move_ok_next = 1'b0;
      solved_next  = 1'b0;
    end
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) state <= IDLE;
    else            state <= state_next;
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      idx       <= 5'd0;
      tgt_row   <= 2'd0;
      tgt_col   <= 2'd0;
      tgt_val   <= 3'd0;
      prev_addr <= 4'd0;
      count     <= 5'd0;
      reject    <= 1'b0;
      move_ok   <= 1'b0;
      solved    <= 1'b0;
    end else begin
      idx       <= idx_next;
      prev_addr <= rd_addr;
      count     <= count_next;
      reject    <= reject_next;
      move_ok   <= move_ok_next;
      solved    <= solved_next;
      if (accept) begin
        tgt_row <= row;
        tgt_col <= col;
        tgt_val <= val;
      end
    end
  end

endmodule

// File: tb/tb_move_checker.sv
// Randomized and directed bench for move_checker; a board memory model answers reads
// and a rule-level sudoku model predicts each move's outcome and timing.
module tb_move_checker;

  logic       clka = 1'b0;
  logic       restart_n;
  logic       check_flag;
  logic       new_game;
  logic [1:0] row;
  logic [1:0] col;
  logic [2:0] val;
  logic [3:0] rd_addr;
  logic [2:0] rd_data = 3'd0;
  logic       rd_given = 1'b0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [2:0] wr_data;
  logic       busy;
  logic       done;
  logic       move_ok;
  logic       solved;

  logic [2:0]  mem [16];
  logic [15:0] given_bits = 16'd0;
  logic        tb_load = 1'b0;
  logic [3:0]  tb_addr = 4'd0;
  logic [2:0]  tb_data = 3'd0;

  int model_board [16];
  int exp_solved;
  int exp_move_ok;
  int tests_run;
  int tests_failed;

  always #5 clka = ~clka;

  move_checker dut (
    .clka(clka), .restart_n(restart_n), .check_flag(check_flag), .new_game(new_game),
    .row(row), .col(col), .val(val), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_given(rd_given), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .move_ok(move_ok), .solved(solved)
  );

  // Board memory: one-cycle read latency, writes visible to the next cycle's read.
  always @(posedge clka) begin
    rd_data  <= mem[rd_addr];
    rd_given <= given_bits[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    else if (tb_load) mem[tb_addr] <= tb_data;
  end

  task checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int model_legal(int r, int c, int v);
    int t;
    t = r * 4 + c;
    if (given_bits[t]) return 0;
    if (v > 4) return 0;
    if (v == 0) return 1;
    for (int i = 0; i < 16; i++) begin
      int ri, ci;
      ri = i / 4;
      ci = i % 4;
      if (i != t && (ri == r || ci == c || (ri / 2 == r / 2 && ci / 2 == c / 2)) &&
          model_board[i] == v)
        return 0;
    end
    return 1;
  endfunction

  function automatic int model_full();
    for (int i = 0; i < 16; i++) if (model_board[i] == 0) return 0;
    return 1;
  endfunction

  task load_cell(input int a, input int v);
    @(negedge clka);
    tb_load = 1'b1;
    tb_addr = 4'(a);
    tb_data = 3'(v);
    model_board[a] = v;
    @(negedge clka);
    tb_load = 1'b0;
  endtask

  task load_all(input int v);
    for (int i = 0; i < 16; i++) load_cell(i, v);
  endtask

  // abort_kind: 0 none, 1 reset pulse, 2 new_game; abort_cycle counts from acceptance.
  task applyStimulus(input int r, input int c, input int v,
                     input int abort_cycle, input int abort_kind, input string tag);
    int legal, t, wr_count, wr_at, done_count, done_at, aborted, exp_wr;
    legal = model_legal(r, c, v);
    t = r * 4 + c;
    aborted = (abort_kind != 0);
    exp_wr = (legal == 1 && (!aborted || abort_cycle > 15)) ? 1 : 0;
    wr_count = 0; wr_at = -1; done_count = 0; done_at = -1;
    @(negedge clka);
    check_flag = 1'b1;
    row = 2'(r);
    col = 2'(c);
    val = 3'(v);
    @(negedge clka);
    check_flag = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clka);
      if (n == 1) checkOutput({tag, "_lock_addr"}, rd_addr, t);
      if (aborted && n == abort_cycle + 1) begin
        checkOutput({tag, "_busy_after_abort"}, busy, 0);
        restart_n = 1'b1;
        new_game  = 1'b0;
      end
      if (wr_en) begin
        wr_count++;
        wr_at = n;
        checkOutput({tag, "_wr_addr"}, wr_addr, t);
        checkOutput({tag, "_wr_data"}, wr_data, v);
      end
      if (done) begin
        done_count++;
        done_at = n;
        checkOutput({tag, "_move_ok_at_done"}, move_ok, legal);
      end
      if (n == abort_cycle && abort_kind == 1) begin
        restart_n = 1'b0;
        #1;
        checkOutput({tag, "_rst_busy"}, busy, 0);
        checkOutput({tag, "_rst_done"}, done, 0);
        checkOutput({tag, "_rst_wr_en"}, wr_en, 0);
        checkOutput({tag, "_rst_rd_addr"}, rd_addr, 0);
        checkOutput({tag, "_rst_solved"}, solved, 0);
      end else if (n == abort_cycle && abort_kind == 2) begin
        new_game = 1'b1;
      end
    end
    checkOutput({tag, "_wr_count"}, wr_count, exp_wr);
    if (exp_wr == 1) checkOutput({tag, "_wr_cycle"}, wr_at, 15);
    checkOutput({tag, "_done_count"}, done_count, aborted ? 0 : 1);
    if (!aborted) checkOutput({tag, "_done_cycle"}, done_at, legal ? 33 : 15);
    if (exp_wr == 1) model_board[t] = v;
    if (aborted) begin
      exp_solved = 0;
      exp_move_ok = 0;
    end else begin
      if (legal == 1) exp_solved = model_full();
      exp_move_ok = legal;
    end
    checkOutput({tag, "_solved"}, solved, exp_solved);
    checkOutput({tag, "_move_ok_held"}, move_ok, exp_move_ok);
    checkOutput({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int sol [16];
    int done_cycles [4];
    int dcount, wcount;
    tests_run = 0;
    tests_failed = 0;
    exp_solved = 0;
    exp_move_ok = 0;
    restart_n = 1'b0;
    check_flag = 1'b0;
    new_game = 1'b0;
    row = 2'd0; col = 2'd0; val = 3'd0;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_wr_en", wr_en, 0);
    checkOutput("reset_rd_addr", rd_addr, 0);
    checkOutput("reset_move_ok", move_ok, 0);
    checkOutput("reset_solved", solved, 0);
    @(negedge clka);
    restart_n = 1'b1;
    load_all(0);

    applyStimulus(1, 2, 3, 0, 0, "empty_accept");
    load_all(0);
    load_cell(0, 2);
    applyStimulus(3, 0, 2, 0, 0, "col_conflict");
    given_bits = 16'h0001;
    applyStimulus(0, 0, 0, 0, 0, "given_clear");
    given_bits = 16'h0000;
    applyStimulus(2, 2, 5, 0, 0, "val_range");

    sol = '{1, 2, 3, 4, 3, 4, 1, 2, 2, 1, 4, 3, 4, 3, 2, 0};
    for (int i = 0; i < 16; i++) load_cell(i, sol[i]);
    applyStimulus(3, 3, 1, 0, 0, "fill_last");
    applyStimulus(3, 3, 0, 0, 0, "clear_last");

    load_all(0);
    applyStimulus(1, 2, 4, 10, 1, "reset_mid");
    applyStimulus(0, 1, 2, 10, 2, "newgame_scan");
    applyStimulus(2, 1, 3, 20, 2, "newgame_count");

    load_all(0);
    dcount = 0;
    wcount = 0;
    @(negedge clka);
    check_flag = 1'b1;
    row = 2'd0; col = 2'd0; val = 3'd1;
    for (int n = 0; n <= 110; n++) begin
      @(negedge clka);
      if (n == 60) check_flag = 1'b0;
      if (wr_en) wcount++;
      if (done) begin
        if (dcount < 4) done_cycles[dcount] = n;
        dcount++;
      end
    end
    model_board[0] = 1;
    checkOutput("held_done_count", dcount, 2);
    checkOutput("held_wr_count", wcount, 2);
    if (dcount >= 2) checkOutput("held_done_gap", done_cycles[1] - done_cycles[0], 34);

    for (int k = 0; k < 24; k++) begin
      string tag;
      if (k % 6 == 0) begin
        given_bits = 16'($urandom() & $urandom());
        for (int i = 0; i < 16; i++)
          load_cell(i, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)));
      end
      tag = $sformatf("rand%0d", k);
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 6)), 0, 0, tag);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
